memory_stage: RTL and testbench

//  Pipeline stage directly downstream of the execute stage.
//  - Waits for the data-bus response of the load/store that execute issued.
//  - Aligns, extends and merges load data (LB/LBU/LH/LHU/LW/LWL/LWR).
//  - Forwards its result to decode.
//  - Registers the instruction towards writeback.

---
 rtl/memory_stage.sv | 200 ++++++++++++++++++++
 tb/tb_memory_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: waits for the bus response of the current load/store, aligns
// and merges load data, forwards the result to decode and registers the
// instruction towards writeback.
module memory_stage #(
    parameter bit LOAD_BYPASS = 1'b1,
    parameter int I_MAX       = 16,
    parameter int I_MEM_R     = 0,
    parameter int I_MEM_W     = 1,
    parameter int I_LB        = 2,
    parameter int I_LBU       = 3,
    parameter int I_LH        = 4,
    parameter int I_LHU       = 5,
    parameter int I_LW        = 6,
    parameter int I_LWL       = 7,
    parameter int I_LWR       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      data_rdata,
    input  logic             data_data_ok,
    input  logic             valid_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      inst_i,
    input  logic [I_MAX-1:0] ctrl_i,
    input  logic [31:0]      result_i,
    input  logic [31:0]      eaddr_i,
    input  logic [31:0]      rdata2_i,
    input  logic [4:0]       waddr_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [4:0]       fwd_addr,
    output logic [31:0]      fwd_data,
    output logic             fwd_ok,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [31:0]      pc_o,
    output logic [31:0]      inst_o,
    output logic [I_MAX-1:0] ctrl_o,
    output logic [31:0]      result_o,
    output logic [4:0]       waddr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HELD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        resp_q, resp_d;
    logic               valid_q, valid_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        inst_q, inst_d;
    logic [I_MAX-1:0]   ctrl_q, ctrl_d;
    logic [31:0]        result_q, result_d;
    logic [4:0]         waddr_q, waddr_d;

    logic               is_load;
    logic               mem;
    logic               held;
    logic               resp_now;
    logic               go_held;
    logic [1:0]         off;
    logic [31:0]        rdat;
    logic [4:0]         sh_l;
    logic [4:0]         sh_r;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [31:0]        final_res;
    logic               unused_eaddr;

    assign unused_eaddr = ^eaddr_i[31:2];

    assign is_load  = ctrl_i[I_MEM_R];
    assign mem      = ctrl_i[I_MEM_R] | ctrl_i[I_MEM_W];
    assign held     = (state_q == HELD);
    assign resp_now = valid_i & mem & data_data_ok & !held;
    // Without bypass a load always parks its response first, so decode only
    // ever sees it from the held register.
    assign go_held  = resp_now & (!ready_i | (is_load & !LOAD_BYPASS));

    assign off  = eaddr_i[1:0];
    assign rdat = held ? resp_q : data_rdata;
    assign sh_l = {~off, 3'b000};
    assign sh_r = {off, 3'b000};

    // Completion, stall and forwarding handshakes for the instruction held here.
    always_comb begin
        done_o = 1'b0;
        if (valid_i) begin
            if (!mem)
                done_o = 1'b1;
            else if (is_load && !LOAD_BYPASS)
                done_o = held;
            else
                done_o = data_data_ok | held;
        end
        ready_o  = !valid_i | (done_o & ready_i);
        fwd_addr = valid_i ? waddr_i : 5'd0;
        fwd_ok   = valid_i & done_o & (waddr_i != 5'd0);
        fwd_data = final_res;
    end

    // Load alignment, extension and LWL/LWR merging; everything else passes result_i.
    always_comb begin
        byte_sel  = rdat[sh_r +: 8];
        half_sel  = off[1] ? rdat[31:16] : rdat[15:0];
        final_res = result_i;
        if (is_load) begin
            if (ctrl_i[I_LB])
                final_res = {{24{byte_sel[7]}}, byte_sel};
            else if (ctrl_i[I_LBU])
                final_res = {24'd0, byte_sel};
            else if (ctrl_i[I_LH])
                final_res = {{16{half_sel[15]}}, half_sel};
            else if (ctrl_i[I_LHU])
                final_res = {16'd0, half_sel};
            else if (ctrl_i[I_LW])
                final_res = rdat;
            else if (ctrl_i[I_LWL])
                final_res = (rdat << sh_l) | (rdata2_i & ~(32'hFFFFFFFF << sh_l));
            else if (ctrl_i[I_LWR])
                final_res = (rdat >> sh_r) | (rdata2_i & ~(32'hFFFFFFFF >> sh_r));
        end
    end

    // Next state of the response FSM and capture of a response writeback cannot take yet.
    always_comb begin
        state_d = state_q;
        resp_d  = resp_q;
        case (state_q)
            IDLE, WAIT: begin
                if (valid_i && mem) begin
                    if (resp_now)
                        state_d = go_held ? HELD : IDLE;
                    else
                        state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
                if (go_held)
                    resp_d = data_rdata;
            end
            HELD: begin
                if (ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Writeback-facing register: advances only when writeback accepts.
    always_comb begin
        valid_d  = valid_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        ctrl_d   = ctrl_q;
        result_d = result_q;
        waddr_d  = waddr_q;
        if (ready_i) begin
            valid_d  = valid_i & done_o;
            pc_d     = pc_i;
            inst_d   = inst_i;
            ctrl_d   = ctrl_i;
            result_d = final_res;
            waddr_d  = waddr_i;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            resp_q   <= 32'd0;
            valid_q  <= 1'b0;
            pc_q     <= 32'd0;
            inst_q   <= 32'd0;
            ctrl_q   <= '0;
            result_q <= 32'd0;
            waddr_q  <= 5'd0;
        end else begin
            state_q  <= state_d;
            resp_q   <= resp_d;
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            waddr_q  <= waddr_d;
        end
    end

    assign valid_o  = valid_q;
    assign pc_o     = pc_q;
    assign inst_o   = inst_q;
    assign ctrl_o   = ctrl_q;
    assign result_o = result_q;
    assign waddr_o  = waddr_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed testbench for memory_stage: one bypassing and one non-bypassing
// instance driven from the same stimulus.
module tb_memory_stage;

    localparam logic [15:0] C_ADDU = 16'h0000;
    localparam logic [15:0] C_SW   = 16'h0002;
    localparam logic [15:0] C_LB   = 16'h0005;
    localparam logic [15:0] C_LBU  = 16'h0009;
    localparam logic [15:0] C_LW   = 16'h0041;
    localparam logic [15:0] C_LWL  = 16'h0081;
    localparam logic [15:0] C_LWR  = 16'h0101;

    logic        clk;
    logic        reset;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    logic        valid_i;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic [15:0] ctrl_i;
    logic [31:0] result_i;
    logic [31:0] eaddr_i;
    logic [31:0] rdata2_i;
    logic [4:0]  waddr_i;
    logic        ready_i;

    logic        ready_o, done_o, fwd_ok, valid_o;
    logic [4:0]  fwd_addr, waddr_o;
    logic [31:0] fwd_data, pc_o, inst_o, result_o;
    logic [15:0] ctrl_o;

    logic        nb_ready_o, nb_done_o, nb_fwd_ok, nb_valid_o;
    logic [4:0]  nb_fwd_addr, nb_waddr_o;
    logic [31:0] nb_fwd_data, nb_pc_o, nb_inst_o, nb_result_o;
    logic [15:0] nb_ctrl_o;

    int total = 0;
    int bad   = 0;

    memory_stage #(.LOAD_BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset), .data_rdata(data_rdata), .data_data_ok(data_data_ok),
        .valid_i(valid_i), .pc_i(pc_i), .inst_i(inst_i), .ctrl_i(ctrl_i),
        .result_i(result_i), .eaddr_i(eaddr_i), .rdata2_i(rdata2_i), .waddr_i(waddr_i),
        .ready_o(ready_o), .done_o(done_o), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .fwd_ok(fwd_ok), .ready_i(ready_i), .valid_o(valid_o), .pc_o(pc_o),
        .inst_o(inst_o), .ctrl_o(ctrl_o), .result_o(result_o), .waddr_o(waddr_o)
    );

    memory_stage #(.LOAD_BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .data_rdata(data_rdata), .data_data_ok(data_data_ok),
        .valid_i(valid_i), .pc_i(pc_i), .inst_i(inst_i), .ctrl_i(ctrl_i),
        .result_i(result_i), .eaddr_i(eaddr_i), .rdata2_i(rdata2_i), .waddr_i(waddr_i),
        .ready_o(nb_ready_o), .done_o(nb_done_o), .fwd_addr(nb_fwd_addr),
        .fwd_data(nb_fwd_data), .fwd_ok(nb_fwd_ok), .ready_i(ready_i),
        .valid_o(nb_valid_o), .pc_o(nb_pc_o), .inst_o(nb_inst_o), .ctrl_o(nb_ctrl_o),
        .result_o(nb_result_o), .waddr_o(nb_waddr_o)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] c, input logic [31:0] ea,
                         input logic [31:0] rd, input logic ok, input logic [31:0] rt,
                         input logic [31:0] res, input logic [4:0] wa, input logic rdy);
        valid_i      = v;
        ctrl_i       = c;
        eaddr_i      = ea;
        data_rdata   = rd;
        data_data_ok = ok;
        rdata2_i     = rt;
        result_i     = res;
        waddr_i      = wa;
        ready_i      = rdy;
        pc_i         = 32'h0040_0000 + ea;
        inst_i       = 32'h8C00_0000 | ea;
        #1;
    endtask

    task automatic go_idle();
        drive(1'b0, C_ADDU, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1);
    endtask

    task automatic do_reset();
        go_idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid_o got %b want 0", valid_o); end
        total++; if (result_o !== 32'd0) begin bad++; $display("[TB] FAIL reset_result_o got %h want 0", result_o); end
        total++; if (pc_o !== 32'd0) begin bad++; $display("[TB] FAIL reset_pc_o got %h want 0", pc_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready_o got %b want 1", ready_o); end
    endtask

    task automatic test_byte_loads();
        do_reset();
        drive(1'b1, C_LB, 32'h0000_1003, 32'h80FF_1234, 1'b1, 32'd0, 32'd0, 5'd3, 1'b1);
        total++; if (done_o !== 1'b1) begin bad++; $display("[TB] FAIL lb_done got %b want 1", done_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("[TB] FAIL lb_ready got %b want 1", ready_o); end
        step();
        total++; if (valid_o !== 1'b1) begin bad++; $display("[TB] FAIL lb_valid_o got %b want 1", valid_o); end
        total++; if (result_o !== 32'hFFFF_FF80) begin bad++; $display("[TB] FAIL lb_result got %h want FFFFFF80", result_o); end
        total++; if (pc_o !== 32'h0040_1003) begin bad++; $display("[TB] FAIL lb_pc got %h want 00401003", pc_o); end
        drive(1'b1, C_LBU, 32'h0000_1003, 32'h80FF_1234, 1'b1, 32'd0, 32'd0, 5'd3, 1'b1);
        step();
        total++; if (result_o !== 32'h0000_0080) begin bad++; $display("[TB] FAIL lbu_result got %h want 00000080", result_o); end
        go_idle();
        step();
        total++; if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL lb_idle_valid got %b want 0", valid_o); end
    endtask

    task automatic test_merge_loads();
        do_reset();
        drive(1'b1, C_LWL, 32'h0000_2001, 32'hAABB_CCDD, 1'b1, 32'h1122_3344, 32'd0, 5'd7, 1'b1);
        step();
        total++; if (result_o !== 32'hCCDD_3344) begin bad++; $display("[TB] FAIL lwl_result got %h want CCDD3344", result_o); end
        drive(1'b1, C_LWR, 32'h0000_2002, 32'hAABB_CCDD, 1'b1, 32'h1122_3344, 32'd0, 5'd7, 1'b1);
        step();
        total++; if (result_o !== 32'h1122_AABB) begin bad++; $display("[TB] FAIL lwr_result got %h want 1122AABB", result_o); end
        go_idle();
        step();
    endtask

    task automatic test_store_wait();
        int seen = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, C_SW, 32'h0000_3000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h0000_BEEF, 5'd0, 1'b1);
            total++; if (done_o !== 1'b0) begin bad++; $display("[TB] FAIL sw_wait_done[%0d] got %b want 0", i, done_o); end
            total++; if (ready_o !== 1'b0) begin bad++; $display("[TB] FAIL sw_wait_ready[%0d] got %b want 0", i, ready_o); end
            step();
            if (valid_o === 1'b1) seen++;
        end
        drive(1'b1, C_SW, 32'h0000_3000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h0000_BEEF, 5'd0, 1'b1);
        total++; if (done_o !== 1'b1) begin bad++; $display("[TB] FAIL sw_ok_done got %b want 1", done_o); end
        step();
        if (valid_o === 1'b1) seen++;
        total++; if (result_o !== 32'h0000_BEEF) begin bad++; $display("[TB] FAIL sw_result got %h want 0000BEEF", result_o); end
        go_idle();
        step();
        if (valid_o === 1'b1) seen++;
        step();
        if (valid_o === 1'b1) seen++;
        total++; if (seen !== 1) begin bad++; $display("[TB] FAIL sw_valid_count got %0d want 1", seen); end
    endtask

    task automatic test_held_response();
        do_reset();
        drive(1'b1, C_LW, 32'h0000_4000, 32'hDEAD_BEEF, 1'b1, 32'd0, 32'd0, 5'd9, 1'b0);
        total++; if (ready_o !== 1'b0) begin bad++; $display("[TB] FAIL held_ok_ready got %b want 0", ready_o); end
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, C_LW, 32'h0000_4000, 32'h1234_5678 + i, 1'b0, 32'd0, 32'd0, 5'd9, 1'b0);
            total++; if (fwd_data !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL held_fwd[%0d] got %h want DEADBEEF", i, fwd_data); end
            total++; if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL held_valid[%0d] got %b want 0", i, valid_o); end
            step();
        end
        drive(1'b1, C_LW, 32'h0000_4000, 32'h5555_AAAA, 1'b0, 32'd0, 32'd0, 5'd9, 1'b1);
        total++; if (ready_o !== 1'b1) begin bad++; $display("[TB] FAIL held_release_ready got %b want 1", ready_o); end
        step();
        total++; if (valid_o !== 1'b1) begin bad++; $display("[TB] FAIL held_out_valid got %b want 1", valid_o); end
        total++; if (result_o !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL held_result got %h want DEADBEEF", result_o); end
        go_idle();
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, C_ADDU, 32'h0000_5000, 32'd0, 1'b0, 32'd0, 32'h0000_0055, 5'd4, 1'b1);
        total++; if (fwd_ok !== 1'b1 || fwd_data !== 32'h55) begin bad++; $display("[TB] FAIL addu_fwd got ok=%b data=%h want ok=1 data=00000055", fwd_ok, fwd_data); end
        total++; if (nb_fwd_ok !== 1'b1) begin bad++; $display("[TB] FAIL addu_nb_fwd got %b want 1", nb_fwd_ok); end
        step();
        drive(1'b1, C_LW, 32'h0000_5004, 32'hCAFE_F00D, 1'b1, 32'd0, 32'd0, 5'd5, 1'b1);
        total++; if (fwd_ok !== 1'b1 || fwd_data !== 32'hCAFE_F00D) begin bad++; $display("[TB] FAIL lw_bypass_fwd got ok=%b data=%h want ok=1 data=CAFEF00D", fwd_ok, fwd_data); end
        total++; if (fwd_addr !== 5'd5) begin bad++; $display("[TB] FAIL lw_fwd_addr got %0d want 5", fwd_addr); end
        total++; if (nb_fwd_ok !== 1'b0) begin bad++; $display("[TB] FAIL lw_nb_early_fwd got %b want 0", nb_fwd_ok); end
        total++; if (nb_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL lw_nb_early_ready got %b want 0", nb_ready_o); end
        step();
        total++; if (valid_o !== 1'b1 || result_o !== 32'hCAFE_F00D) begin bad++; $display("[TB] FAIL lw_bypass_out got v=%b r=%h want v=1 r=CAFEF00D", valid_o, result_o); end
        drive(1'b1, C_LW, 32'h0000_5004, 32'h0BAD_0BAD, 1'b0, 32'd0, 32'd0, 5'd5, 1'b1);
        total++; if (nb_fwd_ok !== 1'b1 || nb_fwd_data !== 32'hCAFE_F00D) begin bad++; $display("[TB] FAIL lw_nb_late_fwd got ok=%b data=%h want ok=1 data=CAFEF00D", nb_fwd_ok, nb_fwd_data); end
        step();
        total++; if (nb_valid_o !== 1'b1 || nb_result_o !== 32'hCAFE_F00D) begin bad++; $display("[TB] FAIL lw_nb_out got v=%b r=%h want v=1 r=CAFEF00D", nb_valid_o, nb_result_o); end
        go_idle();
        step();
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        drive(1'b1, C_LW, 32'h0000_6000, 32'd0, 1'b0, 32'd0, 32'd0, 5'd6, 1'b1);
        step();
        total++; if (ready_o !== 1'b0) begin bad++; $display("[TB] FAIL wait_ready got %b want 0", ready_o); end
        go_idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_wait_valid got %b want 0", valid_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("[TB] FAIL rst_wait_ready got %b want 1", ready_o); end
        drive(1'b0, C_ADDU, 32'd0, 32'h7777_7777, 1'b1, 32'd0, 32'd0, 5'd0, 1'b0);
        total++; if (done_o !== 1'b0) begin bad++; $display("[TB] FAIL spurious_done got %b want 0", done_o); end
        step();
        drive(1'b1, C_LW, 32'h0000_6004, 32'h1111_1111, 1'b0, 32'd0, 32'd0, 5'd6, 1'b1);
        total++; if (done_o !== 1'b0) begin bad++; $display("[TB] FAIL after_spurious_done got %b want 0", done_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL after_spurious_valid got %b want 0", valid_o); end
        step();
        drive(1'b1, C_LW, 32'h0000_6004, 32'h0BAD_F00D, 1'b1, 32'd0, 32'd0, 5'd6, 1'b1);
        step();
        total++; if (result_o !== 32'h0BAD_F00D) begin bad++; $display("[TB] FAIL post_reset_lw got %h want 0BADF00D", result_o); end
        go_idle();
        step();
    endtask

    // Runs every scenario in order, then prints the summary.
    initial begin
        reset = 1'b1;
        go_idle();
        test_reset();
        test_byte_loads();
        test_merge_loads();
        test_store_wait();
        test_held_response();
        test_back_to_back();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
